// File: rtl/microwave_uart_pkg.sv
// Shared definitions for the microwave UART command path. The parser and the
// microwave control FSM both import this package for the command codes.
package microwave_uart_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_START     = 8'h01;
  localparam logic [7:0] CMD_STOP      = 8'h02;
  localparam logic [7:0] CMD_SET_TIME  = 8'h03;
  localparam logic [7:0] CMD_SET_POWER = 8'h04;
  localparam logic [7:0] CMD_CLEAR     = 8'h05;

  localparam logic [1:0] ERR_OVERRUN  = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_UNKNOWN  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_CMD = 3'd1,
    ST_GET_DHI = 3'd2,
    ST_GET_DLO = 3'd3,
    ST_GET_CHK = 3'd4,
    ST_PENDING = 3'd5
  } state_t;

  function automatic logic is_known_cmd(input logic [7:0] code);
    return (code == CMD_START)    || (code == CMD_STOP)      ||
           (code == CMD_SET_TIME) || (code == CMD_SET_POWER) ||
           (code == CMD_CLEAR);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in from the UART receiver, validated command and error strobe out.
// slave = the parser, master = whatever feeds bytes and consumes commands.
interface uart_cmd_parser_if;
  logic        i_RX_DV;
  logic [7:0]  i_RX_Byte;
  logic        o_Cmd_Valid;
  logic [7:0]  o_Cmd;
  logic [15:0] o_Cmd_Data;
  logic        i_Cmd_Ack;
  logic        o_Err;
  logic [1:0]  o_Err_Code;

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_Cmd_Ack,
    output o_Cmd_Valid, o_Cmd, o_Cmd_Data, o_Err, o_Err_Code
  );

  modport master (
    output i_RX_DV, i_RX_Byte, i_Cmd_Ack,
    input  o_Cmd_Valid, o_Cmd, o_Cmd_Data, o_Err, o_Err_Code
  );
endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts idle clocks while enabled, clears on every byte,
// and saturates at the terminal count instead of wrapping.
module uart_byte_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 1041700
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] count;

  // Idle-clock counter, held at LAST once reached.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames the UART RX byte stream into checked microwave commands.
//
// state      | meaning
// IDLE       | hunting for the header byte, other bytes dropped silently
// GET_CMD    | expecting the command code
// GET_DHI    | expecting payload high byte
// GET_DLO    | expecting payload low byte
// GET_CHK    | expecting XOR checksum of cmd/payload
// PENDING    | command presented, waiting for ack; bytes here are overruns
module uart_cmd_parser
  import microwave_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 1041700,
  parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
  input logic            i_Clock,
  input logic            i_Reset_n,
  uart_cmd_parser_if.slave bus
);

  state_t      state, state_nxt;
  logic [7:0]  cmd_r, dhi_r, dlo_r;
  logic [7:0]  cmd_out;
  logic [15:0] data_out;
  logic        err_r;
  logic [1:0]  err_code_r;
  logic        in_frame;
  logic        tmo_expired;
  logic        chk_ok;
  logic        err_set;
  logic [1:0]  err_code_nxt;
  logic        load_cmd;
  logic        cmd_valid;

  assign in_frame = (state == ST_GET_CMD) || (state == ST_GET_DHI) ||
                    (state == ST_GET_DLO) || (state == ST_GET_CHK);
  assign chk_ok   = (bus.i_RX_Byte == (cmd_r ^ dhi_r ^ dlo_r));

  uart_byte_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .clear     (bus.i_RX_DV),
    .enable    (in_frame),
    .expired   (tmo_expired)
  );

  // State register.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next state; a byte in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (bus.i_RX_DV && (bus.i_RX_Byte == HEADER)) state_nxt = ST_GET_CMD;
      ST_GET_CMD:
        if (bus.i_RX_DV)
          state_nxt = is_known_cmd(bus.i_RX_Byte) ? ST_GET_DHI : ST_IDLE;
        else if (tmo_expired) state_nxt = ST_IDLE;
      ST_GET_DHI:
        if (bus.i_RX_DV)      state_nxt = ST_GET_DLO;
        else if (tmo_expired) state_nxt = ST_IDLE;
      ST_GET_DLO:
        if (bus.i_RX_DV)      state_nxt = ST_GET_CHK;
        else if (tmo_expired) state_nxt = ST_IDLE;
      ST_GET_CHK:
        if (bus.i_RX_DV)      state_nxt = chk_ok ? ST_PENDING : ST_IDLE;
        else if (tmo_expired) state_nxt = ST_IDLE;
      ST_PENDING:
        if (bus.i_Cmd_Ack)    state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: error requests, command load and the valid flag.
  always_comb begin
    err_set      = 1'b0;
    err_code_nxt = ERR_OVERRUN;
    load_cmd     = 1'b0;
    cmd_valid    = (state == ST_PENDING);
    if (in_frame && !bus.i_RX_DV && tmo_expired) begin
      err_set      = 1'b1;
      err_code_nxt = ERR_TIMEOUT;
    end
    if (bus.i_RX_DV) begin
      case (state)
        ST_GET_CMD:
          if (!is_known_cmd(bus.i_RX_Byte)) begin
            err_set      = 1'b1;
            err_code_nxt = ERR_UNKNOWN;
          end
        ST_GET_CHK:
          if (chk_ok) begin
            load_cmd = 1'b1;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_CHECKSUM;
          end
        ST_PENDING: begin
          err_set      = 1'b1;
          err_code_nxt = ERR_OVERRUN;
        end
        default: ;
      endcase
    end
  end

  // Frame capture, presented command, and the registered error strobe/code.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cmd_r      <= '0;
      dhi_r      <= '0;
      dlo_r      <= '0;
      cmd_out    <= '0;
      data_out   <= '0;
      err_r      <= 1'b0;
      err_code_r <= ERR_OVERRUN;
    end else begin
      if (bus.i_RX_DV) begin
        case (state)
          ST_GET_CMD: cmd_r <= bus.i_RX_Byte;
          ST_GET_DHI: dhi_r <= bus.i_RX_Byte;
          ST_GET_DLO: dlo_r <= bus.i_RX_Byte;
          default: ;
        endcase
      end
      if (load_cmd) begin
        cmd_out  <= cmd_r;
        data_out <= {dhi_r, dlo_r};
      end
      err_r <= err_set;
      if (err_set) err_code_r <= err_code_nxt;
    end
  end

  assign bus.o_Cmd_Valid = cmd_valid;
  assign bus.o_Cmd       = cmd_out;
  assign bus.o_Cmd_Data  = data_out;
  assign bus.o_Err       = err_r;
  assign bus.o_Err_Code  = err_code_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames with literal expectations, then
// randomized traffic checked every cycle against a frame-queue model.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(
    .TIMEOUT_CLKS (TMO),
    .HEADER       (8'hA5)
  ) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  frame_q[$];
  int          gap = 0;
  bit          m_pend = 1'b0;
  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_data = 16'h0000;
  bit          m_err = 1'b0;
  logic [1:0]  m_code = 2'd0;

  task automatic model_step();
    if (!rst_n) begin
      frame_q.delete();
      gap = 0; m_pend = 0; m_cmd = 0; m_data = 0; m_err = 0; m_code = 0;
    end else begin
      m_err = 0;
      if (m_pend) begin
        if (bus.i_RX_DV) begin m_err = 1; m_code = 2'd0; end
        if (bus.i_Cmd_Ack) m_pend = 0;
      end else if (bus.i_RX_DV) begin
        gap = 0;
        if (frame_q.size() == 0) begin
          if (bus.i_RX_Byte == 8'hA5) frame_q.push_back(bus.i_RX_Byte);
        end else begin
          frame_q.push_back(bus.i_RX_Byte);
          if (frame_q.size() == 2 && !(frame_q[1] >= 8'd1 && frame_q[1] <= 8'd5)) begin
            m_err = 1; m_code = 2'd2; frame_q.delete();
          end else if (frame_q.size() == 5) begin
            if (frame_q[4] == (frame_q[1] ^ frame_q[2] ^ frame_q[3])) begin
              m_pend = 1; m_cmd = frame_q[1]; m_data = {frame_q[2], frame_q[3]};
            end else begin
              m_err = 1; m_code = 2'd1;
            end
            frame_q.delete();
          end
        end
      end else if (frame_q.size() != 0) begin
        gap++;
        if (gap == int'(TMO)) begin
          m_err = 1; m_code = 2'd3; frame_q.delete();
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      check("m_valid", bus.o_Cmd_Valid, m_pend);
      check("m_err", bus.o_Err, m_err);
      check("m_code", bus.o_Err_Code, m_code);
      check("m_cmd", bus.o_Cmd, m_cmd);
      check("m_data", bus.o_Cmd_Data, m_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_RX_DV = 1'b1;
    bus.i_RX_Byte = b;
    tick();
    bus.i_RX_DV = 1'b0;
  endtask

  task automatic rstep(input bit dv, input logic [7:0] b);
    bus.i_Cmd_Ack = ($urandom_range(0, 3) == 0);
    bus.i_RX_DV = dv;
    bus.i_RX_Byte = dv ? b : 8'($urandom);
    tick();
    bus.i_RX_DV = 1'b0;
  endtask

  task automatic rbyte(input logic [7:0] b);
    int n;
    n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(45, 55)) : int'($urandom_range(0, 2));
    repeat (n) rstep(1'b0, 8'h00);
    rstep(1'b1, b);
  endtask

  initial begin
    logic [7:0] c, dh, dl, ck;
    int kind;

    bus.i_RX_DV = 1'b0;
    bus.i_RX_Byte = 8'h00;
    bus.i_Cmd_Ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    check("rst_valid", bus.o_Cmd_Valid, 0);
    check("rst_cmd", bus.o_Cmd, 0);
    check("rst_data", bus.o_Cmd_Data, 0);
    check("rst_err", bus.o_Err, 0);
    check("rst_code", bus.o_Err_Code, 0);

    // Good START frame, ack three cycles after valid rises.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h3C);
    check("start_pre_valid", bus.o_Cmd_Valid, 0);
    send(8'h3D);
    check("start_valid", bus.o_Cmd_Valid, 1);
    check("start_cmd", bus.o_Cmd, 8'h01);
    check("start_data", bus.o_Cmd_Data, 16'h003C);
    repeat (3) tick();
    check("start_hold", bus.o_Cmd_Valid, 1);
    bus.i_Cmd_Ack = 1'b1; tick(); bus.i_Cmd_Ack = 1'b0;
    check("start_acked", bus.o_Cmd_Valid, 0);

    // Bad checksum, then the corrected frame with a first-cycle ack.
    send(8'hA5); send(8'h03); send(8'h01); send(8'h2C); send(8'hFF);
    check("badchk_err", bus.o_Err, 1);
    check("badchk_code", bus.o_Err_Code, 1);
    check("badchk_valid", bus.o_Cmd_Valid, 0);
    tick();
    check("badchk_pulse", bus.o_Err, 0);
    check("badchk_hold", bus.o_Err_Code, 1);
    send(8'hA5); send(8'h03); send(8'h01); send(8'h2C); send(8'h2E);
    check("good2_valid", bus.o_Cmd_Valid, 1);
    check("good2_cmd", bus.o_Cmd, 8'h03);
    check("good2_data", bus.o_Cmd_Data, 16'h012C);
    bus.i_Cmd_Ack = 1'b1; tick(); bus.i_Cmd_Ack = 1'b0;
    check("good2_acked", bus.o_Cmd_Valid, 0);

    // Header right after the ack cycle, then an unknown command code.
    send(8'hA5); send(8'h7E);
    check("unk_err", bus.o_Err, 1);
    check("unk_code", bus.o_Err_Code, 2);
    send(8'h00); check("unk_tail0", bus.o_Err, 0);
    send(8'h11); check("unk_tail1", bus.o_Err, 0);
    send(8'h6F); check("unk_tail2", bus.o_Err, 0);

    // Timeout at the 50th idle clock after the last strobe.
    send(8'hA5); send(8'h02); send(8'h00);
    repeat (TMO - 1) tick();
    check("tmo_early", bus.o_Err, 0);
    tick();
    check("tmo_err", bus.o_Err, 1);
    check("tmo_code", bus.o_Err_Code, 3);

    // Byte arriving in the expiry cycle wins.
    send(8'hA5); send(8'h02); send(8'h00);
    repeat (TMO - 1) tick();
    send(8'h00);
    check("tmo_edge_noerr", bus.o_Err, 0);
    send(8'h02);
    check("tmo_edge_valid", bus.o_Cmd_Valid, 1);
    check("tmo_edge_cmd", bus.o_Cmd, 8'h02);

    // Overrun while pending: two bytes, then a byte coincident with the ack.
    send(8'h11);
    check("ovr1_err", bus.o_Err, 1);
    check("ovr1_code", bus.o_Err_Code, 0);
    send(8'hA5);
    check("ovr2_err", bus.o_Err, 1);
    check("ovr2_valid", bus.o_Cmd_Valid, 1);
    check("ovr2_cmd", bus.o_Cmd, 8'h02);
    check("ovr2_data", bus.o_Cmd_Data, 16'h0000);
    bus.i_Cmd_Ack = 1'b1; send(8'h33); bus.i_Cmd_Ack = 1'b0;
    check("ovr_ack_valid", bus.o_Cmd_Valid, 0);
    check("ovr_ack_err", bus.o_Err, 1);
    check("ovr_ack_code", bus.o_Err_Code, 0);
    tick();
    check("ovr_ack_pulse", bus.o_Err, 0);

    // Reset between DATA_LO and CHK.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", bus.o_Cmd_Valid, 0);
    check("rst_mid_cmd", bus.o_Cmd, 0);
    check("rst_mid_data", bus.o_Cmd_Data, 0);
    check("rst_mid_err", bus.o_Err, 0);
    tick();
    rst_n = 1'b1;
    send(8'h3D);
    check("rst_chk_ignored", bus.o_Err, 0);
    check("rst_chk_novalid", bus.o_Cmd_Valid, 0);
    send(8'hA5); send(8'h05); send(8'h12); send(8'h34); send(8'h23);
    check("rst_next_valid", bus.o_Cmd_Valid, 1);
    check("rst_next_cmd", bus.o_Cmd, 8'h05);
    check("rst_next_data", bus.o_Cmd_Data, 16'h1234);
    bus.i_Cmd_Ack = 1'b1; tick(); bus.i_Cmd_Ack = 1'b0;

    // Randomized traffic with random acks; the per-cycle compare does the checking.
    for (int it = 0; it < 400; it++) begin
      kind = int'($urandom_range(0, 4));
      c  = 8'($urandom_range(1, 5));
      dh = 8'($urandom);
      dl = 8'($urandom);
      ck = c ^ dh ^ dl;
      case (kind)
        0: begin rbyte(8'hA5); rbyte(c); rbyte(dh); rbyte(dl); rbyte(ck); end
        1: begin rbyte(8'hA5); rbyte(c); rbyte(dh); rbyte(dl); rbyte(ck ^ 8'($urandom_range(1, 255))); end
        2: begin
          do c = 8'($urandom); while (c >= 8'd1 && c <= 8'd5);
          rbyte(8'hA5); rbyte(c); rbyte(dh); rbyte(dl);
        end
        3: repeat ($urandom_range(1, 4)) rbyte(8'($urandom));
        default: begin
          rbyte(8'hA5);
          if ($urandom_range(0, 1) == 1) rbyte(c);
          if ($urandom_range(0, 1) == 1) rbyte(dh);
          repeat ($urandom_range(45, 55)) rstep(1'b0, 8'h00);
        end
      endcase
      repeat ($urandom_range(0, 3)) rstep(1'b0, 8'h00);
    end
    bus.i_Cmd_Ack = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
